// File: rtl/qru_iter.sv
// qru_iter -- iterative quotient/remainder unit (RV32M DIV/DIVU/REM/REMU,
// generalised to XLEN bits). Restoring radix-2 division, one quotient bit
// per iteration, followed by a sign-fix cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   a, b                dividend, divisor
//   qructl              func3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   out_valid/out_ready result handshake
//   qrures              quotient or remainder, held until next result
//   busy                high whenever the FSM is not IDLE
//   kill                abort (present only with QRU_KILL_EN)
//
// Optional feature macro: QRU_KILL_EN.
//
// Latency: the first division step is taken on the accept edge from the
// freshly decoded operands, so CALC finishes the remaining XLEN-1 steps,
// FIX registers the result, and out_valid rises XLEN+1 cycles after accept.
// Divide-by-zero and signed overflow go straight to DONE (1 cycle).
module qru_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      qructl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] qrures,
  output logic            busy
`ifdef QRU_KILL_EN
  ,
  input  logic            kill
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   quo, dvs;
  logic              op_rem, qsgn, rsgn;

  logic kill_i;
`ifdef QRU_KILL_EN
  assign kill_i = kill;
`else
  assign kill_i = 1'b0;
`endif

  // operand decode
  logic            sgn_op, b_zero, ovf, special, accept;
  logic [XLEN-1:0] abs_a, abs_b, spec_res;

  assign sgn_op  = ~qructl[0];
  assign abs_a   = (sgn_op & a[XLEN-1]) ? -a : a;
  assign abs_b   = (sgn_op & b[XLEN-1]) ? -b : b;
  assign b_zero  = (b == '0);
  assign ovf     = sgn_op & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
  assign special = b_zero | ovf;
  assign accept  = in_valid & in_ready;
  assign spec_res = b_zero ? (qructl[1] ? a : '1) : (qructl[1] ? '0 : a);

  // one restoring step; in IDLE it runs on the incoming operands so the
  // accept edge already performs iteration 1
  logic [XLEN:0]   st_rem, rem_nxt;
  logic [XLEN-1:0] st_quo, st_dvs, quo_nxt;
  logic [XLEN+1:0] shl, diff;

  always_comb begin
    st_rem = rem;
    st_quo = quo;
    st_dvs = dvs;
    if (state == IDLE) begin
      st_rem = '0;
      st_quo = abs_a;
      st_dvs = abs_b;
    end
    shl     = {st_rem, st_quo[XLEN-1]};
    diff    = shl - {2'b00, st_dvs};
    rem_nxt = diff[XLEN+1] ? shl[XLEN:0] : diff[XLEN:0];
    quo_nxt = {st_quo[XLEN-2:0], ~diff[XLEN+1]};
  end

  logic [XLEN-1:0] q_fix, r_fix;
  assign q_fix = qsgn ? -quo : quo;
  assign r_fix = rsgn ? -rem[XLEN-1:0] : rem[XLEN-1:0];

  // next state / outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) state_nxt = special ? DONE : CALC;
      end
      CALC: if (cnt == CNT_W'(XLEN-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill_i && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      op_rem <= 1'b0;
      qsgn   <= 1'b0;
      rsgn   <= 1'b0;
      qrures <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          op_rem <= qructl[1];
          qsgn   <= sgn_op & (a[XLEN-1] ^ b[XLEN-1]);
          rsgn   <= sgn_op & a[XLEN-1];
          dvs    <= abs_b;
          rem    <= rem_nxt;
          quo    <= quo_nxt;
          cnt    <= CNT_W'(1);
          if (special) qrures <= spec_res;
        end
        CALC: if (!kill_i) begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: if (!kill_i) qrures <= op_rem ? r_fix : q_fix;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qru_iter.sv
module tb_qru_iter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] a = '0, b = '0;
  logic [1:0]      qructl = 2'b00;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] qrures;
  logic            busy;
`ifdef QRU_KILL_EN
  logic            kill = 1'b0;
`endif

  qru_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .qructl(qructl), .out_valid(out_valid),
    .out_ready(out_ready), .qrures(qrures), .busy(busy)
`ifdef QRU_KILL_EN
    , .kill(kill)
`endif
  );

  always #5 clk = ~clk;

  int              errs = 0, checks = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_res = '0;

  task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    if (y == 0) return op[1] ? x : '1;
    if (!op[0] && x == 32'h8000_0000 && y == '1) return op[1] ? '0 : x;
    if (!op[0]) return op[1] ? 32'(sx % sy) : 32'(sx / sy);
    return op[1] ? (x % y) : (x / y);
  endfunction

  // drive one op, hold out_ready low for 'hold' cycles once DONE
  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y, input int hold);
    int              lat, exp_lat;
    logic [XLEN-1:0] held;
    exp_lat = (y == 0 || (!op[0] && x == 32'h8000_0000 && y == '1)) ? 1 : XLEN + 1;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    out_ready = (hold == 0);
    qructl = op; a = x; b = y; in_valid = 1'b1;
    exp_q.push_back(model(op, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("busy_done", busy, 1);
    if (exp_q.size() > 0) begin
      last_res = exp_q.pop_front();
      chk("qrures", qrures, last_res);
    end
    held = qrures;
    repeat (hold) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom; qructl = 2'($urandom);
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_stable", qrures, held);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid_low", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_busy_low", busy, 0);
    @(posedge clk); #1;
    chk("idle_hold", qrures, held);
  endtask

  // start an op and leave it mid-CALC after 'n' iterations
  task automatic start_partial(input logic [1:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y, input int n);
    @(negedge clk);
    qructl = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_qrures", qrures, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b01, 32'd100, 32'd7, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(2'b01, 32'd5, 32'd0, 0);
    run_op(2'b10, 32'd5, 32'd0, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(2'b00, 32'h8000_0000, 32'd3, 0);
    run_op(2'b11, 32'hDEAD_BEEF, 32'h0001_2345, 5);
    for (int i = 0; i < 8; i++)
      run_op(2'($urandom), $urandom, (i % 2) ? $urandom : 32'($urandom_range(1, 300)), 0);

    // reset in the middle of CALC discards the operation
    start_partial(2'b01, 32'd1000, 32'd3, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_qrures", qrures, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 32'hFFFF_FF00, 32'd16, 0);

`ifdef QRU_KILL_EN
    start_partial(2'b01, 32'd999, 32'd4, 10);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_in_ready", in_ready, 1);
    chk("kill_valid", out_valid, 0);
    chk("kill_qrures", qrures, last_res);
    run_op(2'b11, 32'd999, 32'd4, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
